stereo_mult_scheduler: RTL
==========================

Name: stereo_mult_scheduler

Overview:
- Time-shares one external 18x5 signed sequential multiplier between the L+R (gain Ks) and L-R (gain Kd) paths of the 48 kHz stereo front end.
- On each clken_48 strobe it captures a LEFT/RIGHT/Ks/Kd snapshot and issues two multiply jobs back to back: sum first, then difference.
- It scales both products, then commits both outputs together with a one-cycle valid pulse.
- It sits between the audio sample source and the interpolator inputs (LpR/LmR).

Parameters:
- TIMEOUT_CYC, 64, max cycles to wait for mult_ready per job before aborting.
- SHIFT, 3, arithmetic right shift applied to each product.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- clken_48  in  1  one-cycle 48 kHz sample strobe
- left  in  18  signed left sample
- right  in  18  signed right sample
- ks  in  4  unsigned sum gain
- kd  in  4  unsigned difference gain
- clear_err  in  1  synchronous clear of sticky flags
- mult_start  out  1  one-cycle start to shared multiplier
- mult_a  out  18  signed multiplicand
- mult_b  out  5  signed multiplier ({1'b0,k})
- mult_ready  in  1  multiplier done level
- mult_r  in  23  signed product
- lpr_out  out  18  signed scaled (L+R)/2*Ks
- lmr_out  out  18  signed scaled (L-R)/2*Kd
- out_valid  out  1  one-cycle pulse when both outputs update
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky: strobe arrived while busy
- timeout_err  out  1  sticky: job exceeded TIMEOUT_CYC

Behaviour:
- Reset (async, reset==0):
  - State goes to IDLE; a timeout abort also returns to IDLE.
  - All outputs go to 0, and snapshot registers clear to 0.
- States:
  - IDLE: on clken_48, register left, right, ks, kd, then go to ISSUE_S.
  - ISSUE_S: mult_start=1 for exactly one cycle. mult_a=(left+right)>>>1, computed at 19 bits and exact in 18 bits. mult_b={0,ks}. Go to GUARD_S.
  - GUARD_S: one cycle with mult_ready ignored, because the multiplier drops ready the cycle after start. Go to WAIT_S.
  - WAIT_S: on the first cycle with mult_ready==1, capture mult_r into prod_s and go to ISSUE_D.
  - ISSUE_D, GUARD_D and WAIT_D: same sequence with mult_a=(left-right)>>>1 and mult_b={0,kd}. The product is captured into prod_d, then go to COMMIT.
  - COMMIT: lpr_out=scale(prod_s) and lmr_out=scale(prod_d), registered. out_valid=1 for this cycle only. Next state is IDLE.
- Operand stability: mult_a and mult_b are driven from the snapshot and stay stable from ISSUE through capture. Both hold their last value in IDLE.
- Scaling: prod>>>SHIFT is floor division (20-bit result), truncated to the low 18 bits, which wraps.
- Latency: strobe-to-out_valid = 2*(3+Lm)+2 cycles, where Lm = cycles from GUARD exit until ready.
- Overrun:
  - clken_48 while busy sets overrun and the strobe is dropped; the snapshot is unchanged.
  - clken_48 in the same cycle as COMMIT is also dropped.
- Timeout:
  - A per-job counter resets in ISSUE and increments in GUARD and WAIT.
  - When it reaches TIMEOUT_CYC without ready: set timeout_err, go to IDLE, no out_valid, outputs hold.
- Sticky flags: clear_err clears both overrun and timeout_err. If a set event and clear_err occur in the same cycle, the set wins.

Optional Feature:
- Macro: STEREO_MULT_SATURATE_EN.
- Defined: scale() clamps the 20-bit shifted value to [-131072, 131071] instead of wrapping.
- Undefined: truncation (wrap) as above.

Decomposition:
- Package stereo_mult_pkg holds:
  - width constants SAMPLE_W=18, GAIN_W=5, PROD_W=23;
  - the state enum (IDLE, ISSUE_S, GUARD_S, WAIT_S, ISSUE_D, GUARD_D, WAIT_D, COMMIT);
  - default TIMEOUT_CYC.
- One sub-module, prod_scale: combinational shift plus wrap/saturate, instantiated twice.

Test Plan:
- Basic: left=1000, right=200, ks=8, kd=4, model multiplier ready 5 cycles after GUARD -> lpr_out=600, lmr_out=200, one out_valid pulse exactly 2*(3+5)+2=18 cycles after the strobe.
- Negative: left=-1000, right=-3, ks=15, kd=1 -> mult_a=-502 then -499; lpr_out=-942, lmr_out=-63.
- Overflow: left=right=131071, ks=15 -> lpr_out=-16386 without the macro; lpr_out=131071 with STEREO_MULT_SATURATE_EN.
- Overrun: second clken_48 3 cycles after the first -> overrun=1, outputs match the first snapshot, a single out_valid; clear_err then returns overrun to 0.
- Timeout: model never raises ready, TIMEOUT_CYC=64 -> timeout_err=1, busy drops, no out_valid, lpr_out/lmr_out unchanged; the next strobe with a working model completes normally.
- Reset mid-job: assert reset during WAIT_D -> all outputs 0 immediately (async), state IDLE; after release, the first strobe produces a correct result.

Source files
------------

// File: rtl/stereo_mult_pkg.sv
// rtl/stereo_mult_pkg.sv - widths, FSM states and defaults shared by the stereo multiplier scheduler
package stereo_mult_pkg;

    localparam int SAMPLE_W            = 18;
    localparam int GAIN_W              = 5;
    localparam int PROD_W              = 23;
    localparam int DEFAULT_TIMEOUT_CYC = 64;
    localparam int DEFAULT_SHIFT       = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_S,
        GUARD_S,
        WAIT_S,
        ISSUE_D,
        GUARD_D,
        WAIT_D,
        COMMIT
    } state_t;

endpackage

// File: rtl/stereo_mult_scheduler_prod_scale.sv
// rtl/stereo_mult_scheduler_prod_scale.sv - floor shift of a product to sample width; STEREO_MULT_SATURATE_EN clamps instead of wrapping
module prod_scale
    import stereo_mult_pkg::*;
#(
    parameter int SHIFT = DEFAULT_SHIFT
) (
    input  logic signed [PROD_W-1:0]   prod,
    output logic signed [SAMPLE_W-1:0] scaled
);

`ifdef STEREO_MULT_SATURATE_EN
    logic signed [PROD_W-1:0] shifted;
    logic                     ovf;

    assign shifted = prod >>> SHIFT;
    // In range only when every bit above the sample sign bit repeats the sign
    assign ovf = shifted[PROD_W-1:SAMPLE_W-1] != {(PROD_W-SAMPLE_W+1){shifted[PROD_W-1]}};

    always_comb begin
        scaled = shifted[SAMPLE_W-1:0];
        if (ovf) begin
            scaled = {shifted[PROD_W-1], {(SAMPLE_W-1){~shifted[PROD_W-1]}}};
        end
    end
`else
    assign scaled = SAMPLE_W'(prod >>> SHIFT);
`endif

endmodule

// File: rtl/stereo_mult_scheduler.sv
// rtl/stereo_mult_scheduler.sv - shares one 18x5 multiplier between L+R and L-R paths; STEREO_MULT_SATURATE_EN selects clamped scaling
module stereo_mult_scheduler
    import stereo_mult_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int SHIFT       = DEFAULT_SHIFT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clken_48,
    input  logic signed [SAMPLE_W-1:0] left,
    input  logic signed [SAMPLE_W-1:0] right,
    input  logic        [GAIN_W-2:0]   ks,
    input  logic        [GAIN_W-2:0]   kd,
    input  logic                       clear_err,
    output logic                       mult_start,
    output logic signed [SAMPLE_W-1:0] mult_a,
    output logic signed [GAIN_W-1:0]   mult_b,
    input  logic                       mult_ready,
    input  logic signed [PROD_W-1:0]   mult_r,
    output logic signed [SAMPLE_W-1:0] lpr_out,
    output logic signed [SAMPLE_W-1:0] lmr_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t                     state, state_nxt;
    logic signed [SAMPLE_W-1:0] left_q, right_q;
    logic        [GAIN_W-2:0]   ks_q, kd_q;
    logic                       sel_d;
    logic signed [PROD_W-1:0]   prod_s, prod_d;
    logic        [CNT_W-1:0]    tcnt;
    logic                       load_snap, capture_s, capture_d, job_abort;
    logic                       issuing, guarding, waiting;
    logic signed [SAMPLE_W:0]   sum_w, diff_w;
    logic signed [SAMPLE_W-1:0] lpr_scaled, lmr_scaled;

    // Operands come straight from the snapshot, so they hold through IDLE
    assign sum_w  = {left_q[SAMPLE_W-1], left_q} + {right_q[SAMPLE_W-1], right_q};
    assign diff_w = {left_q[SAMPLE_W-1], left_q} - {right_q[SAMPLE_W-1], right_q};
    assign mult_a = sel_d ? SAMPLE_W'(diff_w >>> 1) : SAMPLE_W'(sum_w >>> 1);
    assign mult_b = {1'b0, (sel_d ? kd_q : ks_q)};

    assign issuing    = (state == ISSUE_S) || (state == ISSUE_D);
    assign guarding   = (state == GUARD_S) || (state == GUARD_D);
    assign waiting    = (state == WAIT_S)  || (state == WAIT_D);
    assign mult_start = issuing;
    assign busy       = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_snap = 1'b0;
        capture_s = 1'b0;
        capture_d = 1'b0;
        job_abort = 1'b0;
        case (state)
            IDLE: begin
                if (clken_48) begin
                    load_snap = 1'b1;
                    state_nxt = ISSUE_S;
                end
            end
            ISSUE_S: state_nxt = GUARD_S;
            GUARD_S: state_nxt = WAIT_S;
            WAIT_S: begin
                if (mult_ready) begin
                    capture_s = 1'b1;
                    state_nxt = ISSUE_D;
                end else if (tcnt >= CNT_LAST) begin
                    job_abort = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ISSUE_D: state_nxt = GUARD_D;
            GUARD_D: state_nxt = WAIT_D;
            WAIT_D: begin
                if (mult_ready) begin
                    capture_d = 1'b1;
                    state_nxt = COMMIT;
                end else if (tcnt >= CNT_LAST) begin
                    job_abort = 1'b1;
                    state_nxt = IDLE;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            left_q      <= '0;
            right_q     <= '0;
            ks_q        <= '0;
            kd_q        <= '0;
            sel_d       <= 1'b0;
            prod_s      <= '0;
            prod_d      <= '0;
            tcnt        <= '0;
            lpr_out     <= '0;
            lmr_out     <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            out_valid <= (state == COMMIT);
            if (load_snap) begin
                left_q  <= left;
                right_q <= right;
                ks_q    <= ks;
                kd_q    <= kd;
                sel_d   <= 1'b0;
            end
            if (capture_s) begin
                prod_s <= mult_r;
                sel_d  <= 1'b1;
            end
            if (capture_d) begin
                prod_d <= mult_r;
            end
            if (issuing) begin
                tcnt <= '0;
            end else if (guarding || waiting) begin
                tcnt <= tcnt + CNT_W'(1);
            end
            if (state == COMMIT) begin
                lpr_out <= lpr_scaled;
                lmr_out <= lmr_scaled;
            end
            // A set event in the same cycle as clear_err keeps the flag raised
            if (clken_48 && busy) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (job_abort) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    prod_scale #(.SHIFT(SHIFT)) u_scale_s (
        .prod   (prod_s),
        .scaled (lpr_scaled)
    );

    prod_scale #(.SHIFT(SHIFT)) u_scale_d (
        .prod   (prod_d),
        .scaled (lmr_scaled)
    );

endmodule
